// File: rtl/sh_word_chain.sv
// Word-granular parallel-in shift chain with a valid/ready input and a packed-vector output.
// Optional ROTATE_EN adds a rot input that rotates data_out by one word when the chain is idle.
module sh_word_chain #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned DEPTH   = 2,
  parameter logic [WORD_W*DEPTH-1:0] RST_VAL = (WORD_W*DEPTH)'('h00AA),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      dir,
`ifdef ROTATE_EN
  input  logic                      rot,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*DEPTH-1:0]   data_out,
  output logic [CNT_W-1:0]          count
);

  localparam int unsigned VecW = WORD_W * DEPTH;

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic            accept, pop;
  logic [VecW-1:0] in_ext, shl, shr;
`ifdef ROTATE_EN
  logic [VecW-1:0] rotl, rotr;
`endif

  // Shifts are expressed on the whole vector so DEPTH==1 needs no special slicing.
  assign in_ext = VecW'(in_data);
  assign shl    = (data_q << WORD_W) | in_ext;
  assign shr    = (data_q >> WORD_W) | (in_ext << (VecW - WORD_W));
`ifdef ROTATE_EN
  assign rotl   = (data_q << WORD_W) | (data_q >> (VecW - WORD_W));
  assign rotr   = (data_q >> WORD_W) | (data_q << (VecW - WORD_W));
`endif

  always_comb begin
    in_ready  = (state_q == StFill) ? 1'b1 : out_ready;
    out_valid = (state_q == StFull);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;

    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;

    if (accept) begin
      data_d = dir ? shr : shl;
    end
`ifdef ROTATE_EN
    else if (rot && !pop) begin
      data_d = dir ? rotr : rotl;
    end
`endif

    unique case (state_q)
      StFill: begin
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          if (count_d == CNT_W'(DEPTH)) state_d = StFull;
        end
      end
      StFull: begin
        if (pop) begin
          if (accept) begin
            count_d = CNT_W'(1);
            state_d = (DEPTH == 1) ? StFull : StFill;
          end else begin
            count_d = '0;
            state_d = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFill;
      data_q  <= RST_VAL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_out = data_q;
  assign count    = count_q;

endmodule

// File: tb/tb_sh_word_chain.sv
// Directed self-checking bench for sh_word_chain at WORD_W=8, DEPTH=2, RST_VAL='h00AA.
module tb_sh_word_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        dir;
`ifdef ROTATE_EN
  logic        rot;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  sh_word_chain #(
    .WORD_W (8),
    .DEPTH  (2),
    .RST_VAL(16'h00AA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .dir      (dir),
`ifdef ROTATE_EN
    .rot      (rot),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [15:0] d, input int c, input logic ov);
    check_eq({tag, "_data"}, 32'(data_out), 32'(d));
    check_eq({tag, "_count"}, 32'(count), c);
    check_eq({tag, "_ovalid"}, 32'(out_valid), 32'(ov));
  endtask

  task automatic push(input logic [7:0] d, input logic dr);
    in_valid = 1'b1;
    in_data  = d;
    dir      = dr;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    dir       = 1'b0;
    out_ready = 1'b0;
`ifdef ROTATE_EN
    rot       = 1'b0;
`endif
    #2;
    step();
    expect_state("reset", 16'h00AA, 0, 1'b0);
    check_eq("reset_iready", 32'(in_ready), 1);

    // Left fill, then a push that must be ignored while full.
    rst = 1'b1;
    push(8'h11, 1'b0);
    expect_state("left1", 16'hAA11, 1, 1'b0);
    push(8'h22, 1'b0);
    expect_state("left2", 16'h1122, 2, 1'b1);
    check_eq("full_iready", 32'(in_ready), 0);
    push(8'h33, 1'b0);
    expect_state("ignored", 16'h1122, 2, 1'b1);

    // Pop and accept in the same cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    dir       = 1'b0;
    #1;
    check_eq("popacc_iready", 32'(in_ready), 1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    expect_state("popacc", 16'h2233, 1, 1'b0);

    // Reset mid-fill with a word offered.
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h44;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    expect_state("midrst", 16'h00AA, 0, 1'b0);

    // Right fill.
    push(8'h11, 1'b1);
    expect_state("right1", 16'h1100, 1, 1'b0);
    push(8'h22, 1'b1);
    expect_state("right2", 16'h2211, 2, 1'b1);

    // Pop without accept holds the data.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    expect_state("pop", 16'h2211, 0, 1'b0);
    step();
    expect_state("idle", 16'h2211, 0, 1'b0);

    // Mixed directions within one fill.
    push(8'h33, 1'b0);
    expect_state("mix1", 16'h1133, 1, 1'b0);
    push(8'h44, 1'b1);
    expect_state("mix2", 16'h4411, 2, 1'b1);

`ifdef ROTATE_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    rot = 1'b1;
    dir = 1'b0;
    step();
    rot = 1'b0;
    expect_state("rotl", 16'h2211, 2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
